arith_unit_param: RTL

Parametrised, fully registered successor to the 16-bit ADD/ADC/SUB arithmetic unit. Adds the following on top of the original unit:
- WIDTH generalisation
- subtract-with-borrow, compare and clear-carry operations
- full N/Z/C/V flag set
- a multi-cycle shift-add unsigned multiply
- a valid/busy/done handshake

It sits between the operand register file and the accumulator writeback path of the datapath.

---
 rtl/arith_unit_param_if.sv | 30 +++
 rtl/arith_unit_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/arith_unit_param_if.sv
// Operand/result bundle between the operand register file, the arithmetic unit
// and the accumulator writeback path.
interface arith_unit_param_if #(
  parameter int WIDTH = 16
);
  logic             iValid;
  logic [2:0]       iOpcode;
  logic [WIDTH-1:0] iPortA;
  logic [WIDTH-1:0] iPortB;
  logic [WIDTH-1:0] oAccumulator;
  logic [WIDTH-1:0] oAccumulatorHi;
  logic             oCarryflag;
  logic             oZeroflag;
  logic             oNegflag;
  logic             oOverflowflag;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iValid, iOpcode, iPortA, iPortB,
    input  oAccumulator, oAccumulatorHi, oCarryflag, oZeroflag,
           oNegflag, oOverflowflag, oBusy, oDone
  );

  modport slave (
    input  iValid, iOpcode, iPortA, iPortB,
    output oAccumulator, oAccumulatorHi, oCarryflag, oZeroflag,
           oNegflag, oOverflowflag, oBusy, oDone
  );
endinterface

// File: rtl/arith_unit_param.sv
// Registered WIDTH-bit arithmetic unit: add/sub families, compare, clear-carry
// and a multi-cycle shift-add unsigned multiply with a busy/done handshake.
//
// state     | meaning
// S_IDLE    | ready; single-cycle ops complete on the accept edge
// S_MUL_RUN | multiply iterating, one multiplier bit per cycle, requests ignored
module arith_unit_param #(
  parameter int WIDTH = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  arith_unit_param_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SBB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_CLRC = 3'b111;

  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_acc_hi, w_acc_hi_nxt;
  logic               r_c, w_c_nxt;
  logic               r_z, w_z_nxt;
  logic               r_n, w_n_nxt;
  logic               r_v, w_v_nxt;
  logic               r_done, w_done_nxt;

  logic               w_accept;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic               w_add_v;
  logic               w_sub_v;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH-1:0] w_prod_step;

  assign w_accept = bus.iValid && (r_state == S_IDLE);
  assign w_cin    = ((bus.iOpcode == OP_ADC) || (bus.iOpcode == OP_SBB)) ? r_c : 1'b0;

  // Bit WIDTH of the difference is the borrow out: set when A < B + Cin.
  assign w_sum   = {1'b0, bus.iPortA} + {1'b0, bus.iPortB} + {{WIDTH{1'b0}}, w_cin};
  assign w_dif   = {1'b0, bus.iPortA} - {1'b0, bus.iPortB} - {{WIDTH{1'b0}}, w_cin};
  assign w_add_v = (bus.iPortA[WIDTH-1] == bus.iPortB[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.iPortA[WIDTH-1]);
  assign w_sub_v = (bus.iPortA[WIDTH-1] != bus.iPortB[WIDTH-1]) &&
                   (w_dif[WIDTH-1] != bus.iPortA[WIDTH-1]);

  // The add's carry lands in the product msb as the whole product shifts right.
  assign w_upper     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_step = {w_upper, r_prod[WIDTH-1:1]};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_prod_nxt   = r_prod;
    w_acc_nxt    = r_acc;
    w_acc_hi_nxt = r_acc_hi;
    w_c_nxt      = r_c;
    w_z_nxt      = r_z;
    w_n_nxt      = r_n;
    w_v_nxt      = r_v;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_done_nxt = 1'b1;
          case (bus.iOpcode)
            OP_ADD, OP_ADC: begin
              w_acc_nxt    = w_sum[WIDTH-1:0];
              w_acc_hi_nxt = '0;
              w_c_nxt      = w_sum[WIDTH];
              w_z_nxt      = (w_sum[WIDTH-1:0] == '0);
              w_n_nxt      = w_sum[WIDTH-1];
              w_v_nxt      = w_add_v;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
              if (bus.iOpcode != OP_CMP) begin
                w_acc_nxt    = w_dif[WIDTH-1:0];
                w_acc_hi_nxt = '0;
              end
              w_c_nxt = w_dif[WIDTH];
              w_z_nxt = (w_dif[WIDTH-1:0] == '0);
              w_n_nxt = w_dif[WIDTH-1];
              w_v_nxt = w_sub_v;
            end
            OP_MUL: begin
              w_done_nxt   = 1'b0;
              w_state_nxt  = S_MUL_RUN;
              w_mcand_nxt  = bus.iPortA;
              w_mplier_nxt = bus.iPortB;
              w_prod_nxt   = '0;
              w_cnt_nxt    = CNT_W'(WIDTH);
            end
            OP_CLRC: w_c_nxt = 1'b0;
            OP_NOP:  w_done_nxt = 1'b1;
            default: w_done_nxt = 1'b1;
          endcase
        end
      end
      S_MUL_RUN: begin
        w_prod_nxt   = w_prod_step;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        // Last iteration writes back on the same edge it completes.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = S_IDLE;
          w_acc_nxt    = w_prod_step[WIDTH-1:0];
          w_acc_hi_nxt = w_prod_step[2*WIDTH-1:WIDTH];
          w_c_nxt      = (w_prod_step[2*WIDTH-1:WIDTH] != '0);
          w_z_nxt      = (w_prod_step == '0);
          w_n_nxt      = w_prod_step[WIDTH-1];
          w_v_nxt      = 1'b0;
          w_done_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_acc_hi <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_prod   <= w_prod_nxt;
      r_acc    <= w_acc_nxt;
      r_acc_hi <= w_acc_hi_nxt;
      r_c      <= w_c_nxt;
      r_z      <= w_z_nxt;
      r_n      <= w_n_nxt;
      r_v      <= w_v_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.oAccumulator   = r_acc;
  assign bus.oAccumulatorHi = r_acc_hi;
  assign bus.oCarryflag     = r_c;
  assign bus.oZeroflag      = r_z;
  assign bus.oNegflag       = r_n;
  assign bus.oOverflowflag  = r_v;
  assign bus.oBusy          = (r_state == S_MUL_RUN);
  assign bus.oDone          = r_done;
endmodule
